// File: rtl/sc_mux_poly_eval_pkg.sv
// Shared constants, FSM state type and bit-manipulation helpers for the
// stochastic-computing mux evaluator.
package sc_pkg;

  localparam int              LFSR_W     = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_ZSUB  = 16'hACE1;  // stands in for a zero seed
  localparam int              ROT_STRIDE = 3;

  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_e;

  // Rotate left by n (0..15); n=0 leaves the word unchanged.
  function automatic logic [LFSR_W-1:0] rotl16(input logic [LFSR_W-1:0] v, input logic [3:0] n);
    logic [4:0] s;
    s = {1'b0, n};
    return (v << s) | (v >> (5'd16 - s));
  endfunction

  function automatic logic [LFSR_W-1:0] bitrev16(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] r;
    for (int b = 0; b < LFSR_W; b++) r[b] = v[LFSR_W-1-b];
    return r;
  endfunction

  // Right-shifting Galois step.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/sc_mux_poly_eval_sng.sv
// Comparator stochastic number generator: emits 1 when the random window
// is below the probability. A probability of 2^PREC always yields 1.
module sc_sng #(
  parameter int PREC = 6
) (
  input  logic [PREC-1:0] win_i,
  input  logic [PREC:0]   prob_i,
  output logic            bit_o
);
  assign bit_o = ({1'b0, win_i} < prob_i);
endmodule

// File: rtl/sc_mux_poly_eval.sv
// Sequential stochastic mux-form polynomial evaluator.
// Optional macro SC_STREAM_OUT_EN adds the registered z_bit/z_valid stream.
module sc_mux_poly_eval
  import sc_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int PREC  = 6,
  parameter int LEN_W = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [15:0]                     seed_i,
  input  logic [SEL_W*(PREC+1)-1:0]       x_prob_i,
  input  logic [(2**SEL_W)*(PREC+1)-1:0]  coef_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [LEN_W:0]                  count_o
`ifdef SC_STREAM_OUT_EN
  ,
  output logic                            z_bit_o,
  output logic                            z_valid_o
`endif
);

  localparam int PW = PREC + 1;
  localparam int NC = 2**SEL_W;

  state_e                     state_q, state_d;
  logic [15:0]                seed_q;
  logic [SEL_W-1:0][PW-1:0]   xp_q;
  logic [NC-1:0][PW-1:0]      cf_q;
  logic [LFSR_W-1:0]          lfsr_q;
  logic [LEN_W:0]             cyc_q;
  logic [LEN_W:0]             count_q;

  logic [SEL_W-1:0]           xb;
  logic [PREC-1:0]            wc;
  logic                       zc;
  logic                       accept, last, run_cmp;

  assign accept  = (state_q == IDLE) && start_i;
  // cyc_q reaching 2^LEN_W marks a spent stream; that final RUN cycle only
  // hands over to DONE without another compare.
  assign last    = cyc_q[LEN_W];
  assign run_cmp = (state_q == RUN) && !last;

  // One SNG per variable, each fed a differently rotated LFSR window.
  for (genvar i = 0; i < SEL_W; i++) begin : g_x
    localparam logic [3:0] ROT = 4'((ROT_STRIDE * i) % LFSR_W);
    logic [PREC-1:0] w;
    assign w = PREC'(rotl16(lfsr_q, ROT));
    sc_sng #(.PREC(PREC)) u_sng (.win_i(w), .prob_i(xp_q[i]), .bit_o(xb[i]));
  end

  // The selected coefficient uses the bit-reversed LFSR as its window.
  assign wc = PREC'(bitrev16(lfsr_q));
  sc_sng #(.PREC(PREC)) u_sng_c (.win_i(wc), .prob_i(cf_q[xb]), .bit_o(zc));

  assign busy_o  = (state_q == SEED) || (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign count_o = count_q;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SEED;
      SEED:    state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, LFSR seeding/advance, cycle and ones counting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seed_q  <= '0;
      xp_q    <= '0;
      cf_q    <= '0;
      lfsr_q  <= LFSR_ZSUB;
      cyc_q   <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        seed_q  <= seed_i;
        xp_q    <= x_prob_i;
        cf_q    <= coef_i;
        count_q <= '0;
      end
      if (state_q == SEED) begin
        lfsr_q <= (seed_q == '0) ? LFSR_ZSUB : seed_q;
        cyc_q  <= '0;
      end
      if (run_cmp) begin
        count_q <= count_q + {{LEN_W{1'b0}}, zc};
        lfsr_q  <= lfsr_step(lfsr_q);
        cyc_q   <= cyc_q + 1'b1;
      end
    end
  end

`ifdef SC_STREAM_OUT_EN
  logic z_bit_q, z_valid_q;
  // Registered copy of each compared output bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      z_bit_q   <= 1'b0;
      z_valid_q <= 1'b0;
    end else begin
      z_valid_q <= run_cmp;
      if (run_cmp) z_bit_q <= zc;
    end
  end
  assign z_bit_o   = z_bit_q;
  assign z_valid_o = z_valid_q;
`endif

endmodule

// File: tb/tb_sc_mux_poly_eval.sv
// Randomised self-checking bench for sc_mux_poly_eval (SEL_W=3, PREC=6, LEN_W=6).
module tb_sc_mux_poly_eval;
  localparam int SEL_W = 3, PREC = 6, LEN_W = 6;
  localparam int PW = PREC + 1, NC = 1 << SEL_W, N = 1 << LEN_W;
  localparam int XW = SEL_W * PW, CW = NC * PW;

  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] seed = 0;
  logic [XW-1:0] x_prob = '0;
  logic [CW-1:0] coef = '0;
  logic busy, done;
  logic [LEN_W:0] count;
`ifdef SC_STREAM_OUT_EN
  logic z_bit, z_valid;
`endif

  sc_mux_poly_eval #(.SEL_W(SEL_W), .PREC(PREC), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .seed_i(seed),
    .x_prob_i(x_prob), .coef_i(coef), .busy_o(busy), .done_o(done), .count_o(count)
`ifdef SC_STREAM_OUT_EN
    , .z_bit_o(z_bit), .z_valid_o(z_valid)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int exp_cnt;
  bit exp_z [0:N-1];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: walk the whole stream with plain arithmetic.
  task automatic model(input logic [15:0] sd, input logic [XW-1:0] xp, input logic [CW-1:0] cf);
    logic [15:0] l, br;
    logic [31:0] dbl;
    int sel, w, wc;
    l = (sd == 0) ? 16'hACE1 : sd;
    exp_cnt = 0;
    for (int t = 0; t < N; t++) begin
      sel = 0;
      for (int i = 0; i < SEL_W; i++) begin
        dbl = {l, l} << ((3 * i) % 16);
        w = int'(dbl[31:16]) % (1 << PREC);
        if (w < int'(xp[i*PW +: PW])) sel += (1 << i);
      end
      for (int b = 0; b < 16; b++) br[b] = l[15-b];
      wc = int'(br) % (1 << PREC);
      exp_z[t] = (wc < int'(cf[sel*PW +: PW]));
      exp_cnt += int'(exp_z[t]);
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
  endtask

  function automatic logic [CW-1:0] rnd_coef();
    logic [CW-1:0] c;
    for (int k = 0; k < NC; k++) c[k*PW +: PW] = PW'($urandom_range(0, 64));
    return c;
  endfunction

  function automatic logic [XW-1:0] rnd_x();
    logic [XW-1:0] x;
    for (int k = 0; k < SEL_W; k++) x[k*PW +: PW] = PW'($urandom_range(0, 64));
    return x;
  endfunction

  // One evaluation; lit<0 means no hand-computed literal for count.
  task automatic run(input string nm, input logic [15:0] sd, input logic [XW-1:0] xp,
                     input logic [CW-1:0] cf, input bit hold, input int abort_at,
                     input int lit, output int got_cnt);
    bit got;
    model(sd, xp, cf);
    got = 0;
    got_cnt = -1;
    @(negedge clk);
    seed = sd; x_prob = xp; coef = cf; start = 1;
    @(posedge clk); #1;
    if (!hold) start = 0;
    seed = 16'($urandom); x_prob = rnd_x(); coef = rnd_coef();
    chk({nm, " busy_seed"}, int'(busy), 1);
    for (int k = 1; k <= 70 && !got; k++) begin
      @(posedge clk); #1;
      if (k == abort_at) begin
        rst_n = 0; #1;
        chk({nm, " abort_busy"}, int'(busy), 0);
        chk({nm, " abort_done"}, int'(done), 0);
        chk({nm, " abort_count"}, int'(count), 0);
`ifdef SC_STREAM_OUT_EN
        chk({nm, " abort_zv"}, int'(z_valid), 0);
        chk({nm, " abort_zb"}, int'(z_bit), 0);
`endif
        @(negedge clk); rst_n = 1;
        return;
      end
`ifdef SC_STREAM_OUT_EN
      chk({nm, " z_valid"}, int'(z_valid), int'(k >= 2 && k <= N + 1));
      if (k >= 2 && k <= N + 1) chk({nm, " z_bit"}, int'(z_bit), int'(exp_z[k-2]));
`endif
      if (done) begin
        got = 1;
        chk({nm, " latency"}, k, N + 2);
        chk({nm, " busy_at_done"}, int'(busy), 0);
        chk({nm, " count"}, int'(count), exp_cnt);
        if (lit >= 0) chk({nm, " count_lit"}, int'(count), lit);
        got_cnt = int'(count);
      end else begin
        chk({nm, " busy_run"}, int'(busy), 1);
      end
    end
    if (!got) chk({nm, " timeout_done"}, 0, 1);
    start = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk({nm, " post_done"}, int'(done), 0);
      chk({nm, " post_busy"}, int'(busy), 0);
      if (got) chk({nm, " count_hold"}, int'(count), got_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, c1, dummy;
    logic [XW-1:0] xp;
    logic [CW-1:0] cf;
    #23;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset count", int'(count), 0);
`ifdef SC_STREAM_OUT_EN
    chk("reset z_valid", int'(z_valid), 0);
    chk("reset z_bit", int'(z_bit), 0);
`endif
    @(negedge clk); rst_n = 1;

    run("coef0", 16'h1234, rnd_x(), '0, 0, 0, 0, dummy);
    cf = '0;
    for (int k = 0; k < NC; k++) cf[k*PW +: PW] = 7'd64;
    run("coef64", 16'h5A5A, rnd_x(), cf, 0, 0, 64, dummy);
    cf = '0; cf[5*PW +: PW] = 7'd64;
    xp = '0; xp[2*PW +: PW] = 7'd64; xp[0 +: PW] = 7'd64;
    run("sel5", 16'hBEEF, xp, cf, 0, 0, 64, dummy);
    xp = '0; xp[0 +: PW] = 7'd64;
    run("sel1", 16'hBEEF, xp, cf, 0, 0, 0, dummy);

    run("hold", 16'h0F0F, rnd_x(), rnd_coef(), 1, 0, -1, dummy);

    cf = '0;
    for (int k = 0; k < NC; k++) cf[k*PW +: PW] = 7'd64;
    run("abort", 16'h7777, rnd_x(), cf, 0, 21, -1, dummy);
    run("after_abort", 16'h7777, rnd_x(), rnd_coef(), 0, 0, -1, dummy);

    xp = rnd_x(); cf = rnd_coef();
    run("seed0", 16'h0000, xp, cf, 0, 0, -1, c0);
    run("seedACE1", 16'hACE1, xp, cf, 0, 0, -1, c1);
    chk("seed0_vs_ACE1", c0, c1);

    for (int r = 0; r < 6; r++)
      run("random", 16'($urandom), rnd_x(), rnd_coef(), 0, 0, -1, dummy);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sc_mux_poly_eval.md
# sc_mux_poly_eval

Sequential stochastic-computing evaluator for multiplexer-form multivariate functions. It generates SEL_W input bitstreams and 2^SEL_W coefficient bitstreams from binary probabilities using an internal LFSR. The input bits select one coefficient bit per cycle, and the block counts output ones over a stream of 2^LEN_W cycles. It is the clocked, parametrised successor to the fixed 3-select combinational mux blocks produced by the synthesis flow, and sits between the flow's coefficient tables and the result readout.

## Interface
- SEL_W, 3: number of select (variable) inputs; 2^SEL_W coefficients
- PREC, 6: comparator precision in bits; probabilities are PREC+1 bits, range 0..2^PREC
- LEN_W, 8: log2 of stream length
- Reset is asynchronous and active-low; one clock.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request evaluation; sampled only in IDLE
- seed  in  16  LFSR seed, captured on accepted start
- x_prob  in  SEL_W*(PREC+1)  input probabilities, field i at [i*(PREC+1) +: PREC+1]
- coef  in  (2^SEL_W)*(PREC+1)  coefficient probabilities, field k at [k*(PREC+1) +: PREC+1]
- busy  out  1  high in SEED and RUN
- done  out  1  one-cycle pulse; count valid in this cycle
- count  out  LEN_W+1  number of ones in the output stream, held until the next accepted start
- z_bit, z_valid  out  1 each  registered output stream (present only with SC_STREAM_OUT_EN)

## Operation
- FSM: IDLE -> SEED -> RUN -> DONE -> IDLE.
- IDLE: if start=1, capture seed, x_prob and coef into registers, clear count, and go to SEED. The inputs may change after acceptance.
- SEED: load the 16-bit Galois LFSR (taps 16'hB400) with the captured seed. A seed of 0 is replaced by 16'hACE1. Clear the cycle counter and go to RUN.
- RUN, each cycle:
  - w_i = PREC-bit window of the LFSR rotated left by 3*i, taking the low PREC bits.
  - xb[i] = (w_i < x_prob_i).
  - sel = {xb[SEL_W-1..0]}.
  - wc = bit-reverse of the LFSR, taking the low PREC bits.
  - zc = (wc < coef[sel]).
  - count += zc.
  - Advance the LFSR and increment the cycle counter.
- After 2^LEN_W RUN cycles, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- A probability of 2^PREC gives a constant-1 stream. A probability of 0 gives a constant-0 stream.
- count saturates naturally: its maximum is 2^LEN_W and its width is LEN_W+1. It never wraps.
- start while busy or in DONE is ignored and is not queued.
- Reset values: state IDLE, busy=0, done=0, count=0, LFSR=16'hACE1, z_bit=0, z_valid=0.
- Deasserting rst_n mid-run aborts immediately and returns every output to its reset value.

## Timing
- Start accepted at edge E0. SEED occupies E0..E1. RUN covers edges E1+1 through E1+2^LEN_W.
- done is high in the cycle following edge E(2^LEN_W+2), giving a total latency of 2^LEN_W+2 clocks from the accepting edge.
- busy rises the cycle after acceptance and falls when done rises.
- The earliest next start can be accepted on the edge ending the DONE cycle's successor, i.e. in IDLE.
- count updates at the same edge as the RUN compare. No pipeline flush is needed.

## Configuration
- SC_STREAM_OUT_EN:
  - Defined: ports z_bit and z_valid exist. z_bit registers zc each RUN cycle, and z_valid=1 for exactly 2^LEN_W cycles, lagging RUN by one edge.
  - Undefined: the ports and registers are absent, and only count is produced.

## Structure
- Package sc_pkg:
  - LFSR width (16), taps (16'hB400), zero-seed substitute (16'hACE1), rotation stride (3)
  - FSM state enum {IDLE, SEED, RUN, DONE}
  - the rotate and bit-reverse functions
- Sub-module sc_sng: parametrised comparator stochastic number generator (window, prob -> bit). It is instantiated SEL_W+1 times: once per variable and once for the selected coefficient.

## Test plan
- SEL_W=3, PREC=6, LEN_W=6. All coef=0, any x_prob -> done after 66 clocks, count=0.
- All coef=64 -> count=64. coef[5]=64 with the others 0, x_prob={64,0,64} (i=2..0) -> count=64. Same, but x_prob={0,0,64} -> count=0.
- start held high during RUN and DONE -> exactly one done pulse per accepted start. count is unchanged by the ignored starts.
- rst_n pulsed low at RUN cycle 20 -> busy=0, done=0, count=0 immediately. A subsequent start gives a full 66-clock evaluation.
- seed=0 and seed=16'hACE1 with identical probabilities -> identical count. With SC_STREAM_OUT_EN defined, identical z_bit sequences and exactly 64 z_valid cycles.
